// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD write path.
package lcd_pkg;

  // Phases of one bus write. The order matches the order on the wire.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ENABLE = 3'd2,
    HOLD   = 3'd3,
    EXEC   = 3'd4,
    DONE   = 3'd5
  } lcd_state_e;

  // Commands whose execution time is the long one.
  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  // Default timing for a 50 MHz clock (20 ns per cycle).
  localparam int LCD_SETUP_CYC_DEF      = 2;      // 40 ns address setup
  localparam int LCD_EN_CYC_DEF         = 16;     // 320 ns enable pulse
  localparam int LCD_HOLD_CYC_DEF       = 2;      // 40 ns data hold
  localparam int LCD_EXEC_SHORT_CYC_DEF = 2000;   // 40 us ordinary command
  localparam int LCD_EXEC_LONG_CYC_DEF  = 82000;  // 1.64 ms clear/home
  localparam int LCD_CNT_W_DEF          = 17;

  // Clear (0x01) and home (0x02/0x03) need the long wait; character
  // data never does, whatever its value.
  function automatic logic isLongCmd(input logic rs, input logic [7:0] data);
    return (!rs) && ((data == LCD_CMD_CLEAR) ||
                     (data[7:1] == LCD_CMD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter shared by every phase of the write engine.
// Loading N-1 on entry to a phase makes oExpire rise in the phase's
// N-th cycle, which is when the controller moves on.
module lcd_phase_timer #(
  parameter int CNT_W = 17
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iLoad,
  input  logic [CNT_W-1:0] iLoadVal,
  output logic             oExpire
);

  logic [CNT_W-1:0] cnt;

  // Load wins; otherwise count down and park at zero.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt <= '0;
    end else if (iLoad) begin
      cnt <= iLoadVal;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign oExpire = (cnt == '0);

endmodule

// File: rtl/lcd_write_engine.sv
// HD44780-style write-only bus driver. Takes one byte + RS per start/done
// handshake, produces setup / enable / hold timing on the pins, then waits
// out the command's execution time before reporting done.
//
// Handshake: the sequencer raises iStart (a level); its rising edge is
// accepted only while the engine is IDLE, edges at any other time are
// dropped. oBusy is high from the cycle after acceptance through the oDone
// cycle. oDone is a single-cycle pulse; the sequencer must drop iStart and
// raise it again to start the next transfer.
module lcd_write_engine
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = LCD_SETUP_CYC_DEF,
  parameter int EN_CYC         = LCD_EN_CYC_DEF,
  parameter int HOLD_CYC       = LCD_HOLD_CYC_DEF,
  parameter int EXEC_SHORT_CYC = LCD_EXEC_SHORT_CYC_DEF,
  parameter int EXEC_LONG_CYC  = LCD_EXEC_LONG_CYC_DEF,
  parameter int CNT_W          = LCD_CNT_W_DEF
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iStart,
  output logic       oDone,
  output logic       oBusy,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output lcd_state_e oState
);

  // Timer load values: a phase of N cycles loads N-1.
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LOAD    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(EXEC_SHORT_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(EXEC_LONG_CYC - 1);

  lcd_state_e       state;
  lcd_state_e       stateNext;
  logic             startQ;
  logic             accept;
  logic             longCmd;
  logic             timerLoad;
  logic [CNT_W-1:0] timerLoadVal;
  logic             timerExpire;

  // Rising edge of iStart, honoured only when idle.
  assign accept = iStart && !startQ && (state == IDLE);

  lcd_phase_timer #(
    .CNT_W (CNT_W)
  ) uTimer (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .iLoad    (timerLoad),
    .iLoadVal (timerLoadVal),
    .oExpire  (timerExpire)
  );

  // Phase sequencing; each transition reloads the timer for the next phase.
  always_comb begin
    stateNext    = state;
    timerLoad    = 1'b0;
    timerLoadVal = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          stateNext    = SETUP;
          timerLoad    = 1'b1;
          timerLoadVal = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (timerExpire) begin
          stateNext    = ENABLE;
          timerLoad    = 1'b1;
          timerLoadVal = EN_LOAD;
        end
      end
      ENABLE: begin
        if (timerExpire) begin
          stateNext    = HOLD;
          timerLoad    = 1'b1;
          timerLoadVal = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (timerExpire) begin
          stateNext    = EXEC;
          timerLoad    = 1'b1;
          timerLoadVal = longCmd ? LONG_LOAD : SHORT_LOAD;
        end
      end
      EXEC: begin
        if (timerExpire) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State, start-edge register and the command-class latch.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= IDLE;
      startQ  <= 1'b0;
      longCmd <= 1'b0;
    end else begin
      state  <= stateNext;
      startQ <= iStart;
      if (accept) begin
        longCmd <= isLongCmd(iRS, iDATA);
      end
    end
  end

  // Pin and status outputs are all flops, decoded from the next state so
  // they line up with the state register (LCD_EN cannot glitch).
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      LCD_DATA <= 8'h00;
      LCD_RS   <= 1'b0;
      LCD_EN   <= 1'b0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
    end else begin
      if (accept) begin
        LCD_DATA <= iDATA;
        LCD_RS   <= iRS;
      end
      LCD_EN <= (stateNext == ENABLE);
      oBusy  <= (stateNext != IDLE);
      oDone  <= (stateNext == DONE);
    end
  end

  assign LCD_RW = 1'b0;
  assign oState = state;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Bench for lcd_write_engine with short timing (2/4/2/10/50).
module tb_lcd_write_engine;
  import lcd_pkg::*;

  localparam int SETUP = 2;
  localparam int EN    = 4;
  localparam int HOLD  = 2;
  localparam int SHORT = 10;
  localparam int LONG  = 50;
  localparam int LAT_SHORT = 1 + SETUP + EN + HOLD + SHORT;  // 19
  localparam int LAT_LONG  = 1 + SETUP + EN + HOLD + LONG;   // 59

  // ---------------- clock / reset ----------------
  logic       iCLK   = 1'b0;
  logic       iRST_N = 1'b0;
  logic [7:0] iDATA  = 8'h00;
  logic       iRS    = 1'b0;
  logic       iStart = 1'b0;
  logic       oDone, oBusy, LCD_RW, LCD_EN, LCD_RS;
  logic [7:0] LCD_DATA;
  lcd_state_e oState;

  always #5 iCLK = ~iCLK;

  lcd_write_engine #(
    .SETUP_CYC      (SETUP),
    .EN_CYC         (EN),
    .HOLD_CYC       (HOLD),
    .EXEC_SHORT_CYC (SHORT),
    .EXEC_LONG_CYC  (LONG),
    .CNT_W          (17)
  ) dut (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .iDATA    (iDATA),
    .iRS      (iRS),
    .iStart   (iStart),
    .oDone    (oDone),
    .oBusy    (oBusy),
    .LCD_DATA (LCD_DATA),
    .LCD_RW   (LCD_RW),
    .LCD_EN   (LCD_EN),
    .LCD_RS   (LCD_RS),
    .oState   (oState)
  );

  int nVec = 0;
  int nMis = 0;

  task automatic check(input string name, input int act, input int exp);
    nVec++;
    if (act != exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         lat;
    bit         holdHigh;    // keep iStart high for 100 cycles past oDone
    bit         midPulse;    // second edge in cycle T0+8
    bit         midChange;   // change iDATA/iRS during ENABLE
    bit         edgeAtDone;  // fresh edge landing in the oDone cycle
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic [7:0] d, input logic rs, input int lat,
                                 input bit hh, input bit mp, input bit mc, input bit ed);
    vec_t v;
    v.data = d; v.rs = rs; v.lat = lat;
    v.holdHigh = hh; v.midPulse = mp; v.midChange = mc; v.edgeAtDone = ed;
    vecs.push_back(v);
  endfunction

  // ---------------- driver: one transfer, checked cycle by cycle ----------------
  // j counts cycles from the acceptance cycle T0 (j=0), sampled at negedge.
  task automatic doWrite(input vec_t v, input string tag);
    int   enFirst, enCnt, enRuns, doneAt, doneCnt, busyBad, dataBad, rsBad, extraBusy;
    logic enPrev;
    enFirst = -1; enCnt = 0; enRuns = 0; doneAt = -1; doneCnt = 0;
    busyBad = 0; dataBad = 0; rsBad = 0; extraBusy = 0; enPrev = 1'b0;
    @(posedge iCLK); #1;
    iDATA = v.data; iRS = v.rs; iStart = 1'b1;
    for (int j = 0; j <= v.lat + 3; j++) begin
      @(negedge iCLK);
      if (LCD_EN) begin
        enCnt++;
        if (enFirst < 0) enFirst = j;
        if (!enPrev) enRuns++;
      end
      enPrev = LCD_EN;
      if (oDone) begin
        doneCnt++;
        if (doneAt < 0) doneAt = j;
      end
      if (oBusy != (j >= 1 && j <= v.lat)) busyBad++;
      if (j >= 1 && j <= v.lat) begin
        if (LCD_DATA != v.data) dataBad++;
        if (LCD_RS != v.rs) rsBad++;
      end
      if (j == 2 && !v.holdHigh) iStart = 1'b0;
      if (v.midPulse && j == 8) iStart = 1'b1;
      if (v.midPulse && j == 10) iStart = 1'b0;
      if (v.midChange && j == 4) begin iDATA = 8'hFF; iRS = ~v.rs; end
      if (v.edgeAtDone && j == v.lat) iStart = 1'b1;
    end
    if (v.holdHigh || v.edgeAtDone) begin
      repeat (100) begin
        @(negedge iCLK);
        if (oBusy || oDone) extraBusy++;
      end
      check({tag, " no_retrigger"}, extraBusy, 0);
    end
    iStart = 1'b0;
    check({tag, " en_first"}, enFirst, 1 + SETUP);
    check({tag, " en_count"}, enCnt, EN);
    check({tag, " en_runs"}, enRuns, 1);
    check({tag, " done_at"}, doneAt, v.lat);
    check({tag, " done_count"}, doneCnt, 1);
    check({tag, " busy_bad"}, busyBad, 0);
    check({tag, " data_bad"}, dataBad, 0);
    check({tag, " rs_bad"}, rsBad, 0);
  endtask

  // ---------------- scoreboard for the init/text sequence ----------------
  logic [8:0] exp_q[$];
  bit   seqOn = 1'b0;
  logic enPrevMon = 1'b0;
  int   seqEnCnt = 0;

  always @(negedge iCLK) begin
    logic [8:0] e;
    if (seqOn && LCD_EN && !enPrevMon) begin
      seqEnCnt++;
      if (exp_q.size() == 0) begin
        check("seq extra_en", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("seq byte%0d", seqEnCnt - 1), int'({LCD_RS, LCD_DATA}), int'(e));
      end
    end
    enPrevMon = LCD_EN;
  end

  // ---------------- test ----------------
  initial begin
    int         doneSeen;
    int         waited;
    logic [8:0] lut[38];
    string      line1, line2;

    // Reset state, checked while reset is still asserted.
    #12;
    check("rst oDone", oDone, 0);
    check("rst oBusy", oBusy, 0);
    check("rst LCD_EN", LCD_EN, 0);
    check("rst LCD_DATA", LCD_DATA, 0);
    check("rst LCD_RS", LCD_RS, 0);
    check("rst LCD_RW", LCD_RW, 0);
    check("rst state", int'(oState), int'(IDLE));
    @(negedge iCLK);
    iRST_N = 1'b1;
    repeat (2) @(negedge iCLK);

    addVec(8'h38, 1'b0, LAT_SHORT, 0, 0, 0, 0);
    addVec(8'h01, 1'b0, LAT_LONG,  0, 0, 0, 0);
    addVec(8'h03, 1'b0, LAT_LONG,  0, 0, 0, 0);
    addVec(8'h02, 1'b0, LAT_LONG,  0, 0, 0, 0);
    addVec(8'h41, 1'b1, LAT_SHORT, 0, 0, 0, 0);
    addVec(8'h01, 1'b1, LAT_SHORT, 0, 0, 0, 0);
    addVec(8'h00, 1'b0, LAT_SHORT, 0, 0, 0, 0);
    addVec(8'h04, 1'b0, LAT_SHORT, 0, 0, 0, 0);
    addVec(8'h38, 1'b0, LAT_SHORT, 1, 0, 0, 0);
    addVec(8'h38, 1'b0, LAT_SHORT, 0, 1, 0, 0);
    addVec(8'h38, 1'b0, LAT_SHORT, 0, 0, 1, 0);
    addVec(8'h5A, 1'b1, LAT_SHORT, 0, 0, 0, 1);

    foreach (vecs[i]) doWrite(vecs[i], $sformatf("vec%0d", i));

    // Reset during ENABLE: everything drops at once, no oDone afterwards.
    @(posedge iCLK); #1;
    iDATA = 8'h38; iRS = 1'b1; iStart = 1'b1;
    repeat (5) @(negedge iCLK);
    check("rstmid en_before", LCD_EN, 1);
    iRST_N = 1'b0;
    #1;
    check("rstmid LCD_EN", LCD_EN, 0);
    check("rstmid LCD_DATA", LCD_DATA, 0);
    check("rstmid LCD_RS", LCD_RS, 0);
    check("rstmid oBusy", oBusy, 0);
    check("rstmid state", int'(oState), int'(IDLE));
    iStart = 1'b0;
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    doneSeen = 0;
    repeat (40) begin
      @(negedge iCLK);
      if (oDone || oBusy) doneSeen++;
    end
    check("rstmid no_done", doneSeen, 0);
    doWrite(vecs[0], "post_rst");

    // Init/text sequence with the sequencer's handshake.
    line1 = "  Hello World!  ";
    line2 = "HD44780 bus drvr";
    lut[0] = {1'b0, 8'h38};
    lut[1] = {1'b0, 8'h0C};
    lut[2] = {1'b0, 8'h01};
    lut[3] = {1'b0, 8'h06};
    lut[4] = {1'b0, 8'h80};
    for (int k = 0; k < 16; k++) lut[5 + k] = {1'b1, line1[k]};
    lut[21] = {1'b0, 8'hC0};
    for (int k = 0; k < 16; k++) lut[22 + k] = {1'b1, line2[k]};

    seqOn = 1'b1;
    for (int i = 0; i < 38; i++) begin
      exp_q.push_back(lut[i]);
      @(posedge iCLK); #1;
      iRS = lut[i][8]; iDATA = lut[i][7:0]; iStart = 1'b1;
      waited = 0;
      while (!oDone && waited < 200) begin
        @(negedge iCLK);
        waited++;
      end
      if (waited >= 200) check($sformatf("seq timeout%0d", i), 0, 1);
      @(posedge iCLK); #1;
      iStart = 1'b0;
    end
    repeat (5) @(negedge iCLK);
    seqOn = 1'b0;
    check("seq en_total", seqEnCnt, 38);
    check("seq leftover", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
